// File: rtl/addsub24_rr_arbiter.sv
// addsub24_rr_arbiter: shares one external 24-bit add/subtract unit between
// NUM_REQ requesters. Grants are round-robin. Operands are registered to drive
// the shared adder, and the result is captured and returned tagged with the
// requester index.
// Optional: define ADDSUB24_OVF_EN to add the resp_ovf signed-overflow output.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no work in flight; arbitrate among req_valid
// EXEC  | registered operands drive the adder; capture result at cycle end
// RESP  | result held on resp_*; on resp_ready, arbitrate for the next one
module addsub24_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*24-1:0]   req_a,
   input  logic [NUM_REQ*24-1:0]   req_b,
   input  logic [NUM_REQ-1:0]      req_sub,
   output logic [23:0]             add_a,
   output logic [23:0]             add_b,
   output logic                    add_sub,
   input  logic [23:0]             add_s,
   input  logic                    add_cout,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [23:0]             resp_data,
   output logic                    resp_cout,
   output logic [ID_W-1:0]         resp_id
`ifdef ADDSUB24_OVF_EN
   ,
   output logic                    resp_ovf
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     pend_id;
   logic [ID_W-1:0]     grant_id;
   logic [NUM_REQ-1:0]  grant_vec;
   logic                grant_found;
   logic                arb_en;
   logic                grant;
   logic [23:0]         sel_a;
   logic [23:0]         sel_b;
   logic                sel_sub;

   // Round-robin search: pass 0 covers indices at or above rr_ptr, pass 1 wraps
   // to indices below it. Operands of the winner are selected in the same loop.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      grant_vec   = '0;
      sel_a       = '0;
      sel_b       = '0;
      sel_sub     = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && ((p == 0) == (i >= int'(rr_ptr)))) begin
               grant_found  = 1'b1;
               grant_id     = ID_W'(i);
               grant_vec[i] = 1'b1;
               sel_a        = req_a[i*24 +: 24];
               sel_b        = req_b[i*24 +: 24];
               sel_sub      = req_sub[i];
            end
         end
      end
   end

   // Grants are only offered in IDLE or when the held result is being accepted.
   // The output is also held low while reset is asserted.
   always_comb begin
      arb_en    = (state == IDLE) || ((state == RESP) && resp_ready);
      grant     = arb_en && grant_found;
      req_ready = (grant && !reset) ? grant_vec : '0;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = grant ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Operand register, round-robin pointer and result capture. The operand
   // register only loads on a grant, so the adder inputs stay quiet when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr     <= '0;
         pend_id    <= '0;
         add_a      <= '0;
         add_b      <= '0;
         add_sub    <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_cout  <= 1'b0;
         resp_id    <= '0;
`ifdef ADDSUB24_OVF_EN
         resp_ovf   <= 1'b0;
`endif
      end else begin
         if (grant) begin
            add_a   <= sel_a;
            add_b   <= sel_b;
            add_sub <= sel_sub;
            pend_id <= grant_id;
            rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
         end
         if (state == EXEC) begin
            resp_valid <= 1'b1;
            resp_data  <= add_s;
            resp_cout  <= add_cout;
            resp_id    <= pend_id;
`ifdef ADDSUB24_OVF_EN
            resp_ovf   <= (add_a[23] == (add_b[23] ^ add_sub)) && (add_s[23] != add_a[23]);
`endif
         end else if ((state == RESP) && resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/addsub24_rr_arbiter.md
Name: addsub24_rr_arbiter

Overview:
- Shares one external 24-bit add/subtract unit (carry-skip adder with `sub` input, sum `S`, carry `cout`) between NUM_REQ requesters.
- Each requester presents operands plus an add/sub select on a valid/ready handshake.
- The block grants round-robin, drives the shared adder from registered operands, captures the result and returns it tagged with the requester index.
- It sits between the TPU accumulate/normalise requesters and the single shared 24-bit adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot grant/accept pulse; the request is consumed on valid&ready.
- req_a  input  NUM_REQ*24  operand A; requester i uses bits [24i+23:24i].
- req_b  input  NUM_REQ*24  operand B, same packing as req_a.
- req_sub  input  NUM_REQ  1 = A-B, 0 = A+B.
- add_a  output  24  to shared adder A.
- add_b  output  24  to shared adder B (raw; the adder applies the sub inversion).
- add_sub  output  1  to shared adder sub.
- add_s  input  24  shared adder sum.
- add_cout  input  1  shared adder carry out (for subtract, 1 = no borrow).
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  24  captured sum/difference.
- resp_cout  output  1  captured carry.
- resp_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (asynchronous, immediate) clears the following: state=IDLE; rr_ptr=0; req_ready=0; resp_valid=0; resp_data=0; resp_cout=0; resp_id=0; add_a=0; add_b=0; add_sub=0. Reset mid-operation discards any in-flight request and result.
- FSM states are IDLE, EXEC and RESP.
- Arbitration, evaluated combinationally in IDLE and in RESP-with-handshake:
  - Search req_valid starting at rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit is granted as index g.
  - req_ready[g]=1 for that cycle only; all other bits are 0. req_ready is never asserted in EXEC.
- On grant:
  - Register req_a[g], req_b[g] and req_sub[g] into the operand register that drives add_a/add_b/add_sub.
  - Register g into the pending id.
  - Set rr_ptr = (g+1) mod NUM_REQ.
  - Next state is EXEC.
- EXEC (one cycle):
  - The adder settles from the registered operands.
  - At the end of the cycle, capture add_s→resp_data, add_cout→resp_cout and pending id→resp_id.
  - Set resp_valid=1. Next state is RESP.
- RESP:
  - resp_valid, resp_data, resp_cout and resp_id are held stable until resp_ready=1.
  - On resp_ready=1 with any req_valid set: grant in the same cycle, go to EXEC, and clear resp_valid at the following edge.
  - On resp_ready=1 with no req_valid: go to IDLE and clear resp_valid.
  - On resp_ready=0: stay in RESP, with no grants.
- IDLE with no req_valid stays in IDLE. rr_ptr is unchanged.
- Latency: grant edge → resp_valid is 2 cycles. Peak throughput is 1 result per 2 cycles.
- The operand register holds its last value when no grant occurs, so adder inputs do not toggle while idle.
- Arithmetic is mod 2^24. There is no saturation and no sign handling inside the block.
- A requester may drop req_valid before being granted; it is then simply skipped.
- Operands are sampled only on the grant cycle.
- Any NUM_REQ ≤ 2**ID_W is legal; unused index values are never produced.

Optional Feature:
- Macro ADDSUB24_OVF_EN.
- When defined:
  - Adds output port resp_ovf (1 bit), captured alongside resp_data.
  - Signed two's-complement overflow = (a[23] == (b[23]^sub)) && (add_s[23] != a[23]), using the registered operands.
  - Reset value 0; held stable in RESP like resp_data.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then single add:
  - Stimulus: req 0, a=0x000005, b=0x000003, sub=0.
  - Response: req_ready[0] pulses; two cycles later resp_valid=1, resp_data=0x000008, resp_cout=0, resp_id=0.
- Subtract with borrow:
  - Stimulus: req 1, a=0x000003, b=0x000005, sub=1.
  - Response: resp_data=0xFFFFFE, resp_cout=0, resp_id=1. With ADDSUB24_OVF_EN, resp_ovf=0.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, resp_ready=1.
  - Response: grants in order 0,1,2,3,0, one every 2 cycles, and resp_id follows the same sequence.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after resp_valid.
  - Response: resp_data and resp_id stay stable, req_ready stays 0 and the next requester waits. When resp_ready rises with a pending req 2, req_ready[2] pulses in the same cycle.
- Wrap/overflow:
  - Stimulus: a=0x7FFFFF, b=0x000001, sub=0.
  - Response: resp_data=0x800000, resp_cout=0, resp_ovf=1 (macro on).
  - Then a=0xFFFFFF, b=0x000001 gives resp_data=0x000000, resp_cout=1.
- Reset mid-operation:
  - Stimulus: assert reset during EXEC.
  - Response: resp_valid=0, req_ready=0 and add_* are 0 immediately. After release, the first grant goes to the lowest valid index (rr_ptr=0).
